// File: rtl/connect_node_nic_pkg.sv
// Shared constants and types for the connect-router node interface.
package connect_node_nic_pkg;

    localparam int CONTROL_W      = 144;
    localparam int FLIT_VALID_BIT = CONTROL_W - 1;

    typedef enum logic {
        INJ_IDLE = 1'b0,
        INJ_HOLD = 1'b1
    } inj_state_e;

endpackage

// File: rtl/nic_eject_fifo.sv
// Show-ahead FIFO for flits ejected by the router; head is visible on rd_data while not empty.
module nic_eject_fifo
    import connect_node_nic_pkg::*;
#(
    parameter int W     = CONTROL_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         wr_fire;
    logic         rd_fire;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count   = wr_q - rd_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_fire) wr_q <= wr_q + 1'b1;
            if (rd_fire) rd_q <= rd_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; validity is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/connect_node_nic.sv
// Node-side endpoint of the connect router: holds one injection flit, buffers ejected flits.
module connect_node_nic
    import connect_node_nic_pkg::*;
#(
    parameter int FLIT_W       = CONTROL_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [FLIT_W-1:0] src_flit,
    output logic              src_ready,
    output logic [FLIT_W-1:0] inj,
    input  logic              accept,
    input  logic [FLIT_W-1:0] eject,
    input  logic              push,
    output logic              bfull,
    output logic              dst_valid,
    output logic [FLIT_W-1:0] dst_flit,
    input  logic              dst_ready,
    output logic              starve,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    inj_state_e        state_q;
    logic [FLIT_W-1:0] inj_q;
    logic              src_ready_q;
    logic [CW-1:0]     starve_cnt_q;
    logic              starve_q;

    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rd_fire;
    logic              wr_fire;
    logic [AW+1:0]     next_count;
    logic              bfull_q, bfull_d;
    logic              overflow_q, overflow_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INJ_IDLE;
            inj_q        <= '0;
            src_ready_q  <= 1'b1;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            case (state_q)
                INJ_IDLE: begin
                    if (src_valid) begin
                        state_q      <= INJ_HOLD;
                        inj_q        <= src_flit;
                        src_ready_q  <= 1'b0;
                        starve_cnt_q <= '0;
                        starve_q     <= 1'b0;
                    end
                end
                INJ_HOLD: begin
                    if (accept) begin
                        state_q      <= INJ_IDLE;
                        inj_q        <= '0;
                        src_ready_q  <= 1'b1;
                        starve_cnt_q <= '0;
                        starve_q     <= 1'b0;
                    end else if (starve_cnt_q != CW'(STARVE_LIMIT)) begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                        starve_q     <= ((starve_cnt_q + 1'b1) == CW'(STARVE_LIMIT));
                    end
                end
                default: state_q <= INJ_IDLE;
            endcase
        end
    end

    nic_eject_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_eject_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (eject),
        .rd_en   (dst_ready),
        .rd_data (dst_flit),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // bfull looks one flit ahead so a push already in flight when the router sees it still fits.
    assign rd_fire    = !fifo_empty && dst_ready;
    assign wr_fire    = push && (!fifo_full || rd_fire);
    assign next_count = {1'b0, fifo_count} + (AW + 2)'(wr_fire) - (AW + 2)'(rd_fire);
    assign bfull_d    = (next_count >= (AW + 2)'(DEPTH - 1));
    assign overflow_d = overflow_q || (push && fifo_full && !rd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            bfull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bfull_q    <= bfull_d;
            overflow_q <= overflow_d;
        end
    end

    assign src_ready = src_ready_q;
    assign inj       = inj_q;
    assign starve    = starve_q;
    assign bfull     = bfull_q;
    assign overflow  = overflow_q;
    assign dst_valid = !fifo_empty;

endmodule

// File: tb/tb_connect_node_nic.sv
// Self-checking bench for connect_node_nic against a queue-based reference model.
module tb_connect_node_nic;

    localparam int FLIT_W = 144;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              src_valid = 1'b0;
    logic [FLIT_W-1:0] src_flit = '0;
    logic              src_ready;
    logic [FLIT_W-1:0] inj;
    logic              accept = 1'b0;
    logic [FLIT_W-1:0] eject = '0;
    logic              push = 1'b0;
    logic              bfull;
    logic              dst_valid;
    logic [FLIT_W-1:0] dst_flit;
    logic              dst_ready = 1'b0;
    logic              starve;
    logic              overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [FLIT_W-1:0] m_q[$];
    logic [FLIT_W-1:0] m_inj = '0;
    bit                m_hold = 1'b0;
    int                m_wait = 0;
    bit                m_overflow = 1'b0;
    bit                m_bfull = 1'b0;

    always #5 clk = ~clk;

    connect_node_nic #(
        .FLIT_W       (FLIT_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_flit  (src_flit),
        .src_ready (src_ready),
        .inj       (inj),
        .accept    (accept),
        .eject     (eject),
        .push      (push),
        .bfull     (bfull),
        .dst_valid (dst_valid),
        .dst_flit  (dst_flit),
        .dst_ready (dst_ready),
        .starve    (starve),
        .overflow  (overflow)
    );

    function automatic logic [FLIT_W-1:0] rand_flit();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[FLIT_W-1:0];
    endfunction

    // Applies one clock edge of the behavioural rules to the model.
    task automatic model_edge();
        bit rd;
        if (rst) begin
            m_q.delete();
            m_inj = '0; m_hold = 0; m_wait = 0; m_overflow = 0; m_bfull = 0;
        end else begin
            rd = (m_q.size() > 0) && dst_ready;
            if (push && m_q.size() == DEPTH && !rd) m_overflow = 1;
            if (rd) void'(m_q.pop_front());
            if (push && (m_q.size() < DEPTH)) m_q.push_back(eject);
            m_bfull = (m_q.size() >= DEPTH - 1);
            if (!m_hold) begin
                if (src_valid) begin m_hold = 1; m_inj = src_flit; m_wait = 0; end
            end else if (accept) begin
                m_hold = 0; m_inj = '0; m_wait = 0;
            end else if (m_wait < LIMIT) begin
                m_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (inj !== '0)       begin n_err++; $display("FAIL reset_inj got %h exp 0", inj); end
        n_vec++; if (bfull !== 1'b0)   begin n_err++; $display("FAIL reset_bfull got %b exp 0", bfull); end
        n_vec++; if (dst_valid !== 1'b0) begin n_err++; $display("FAIL reset_dst_valid got %b exp 0", dst_valid); end
        n_vec++; if (starve !== 1'b0)  begin n_err++; $display("FAIL reset_starve got %b exp 0", starve); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL reset_src_ready got %b exp 1", src_ready); end
    endtask

    task automatic test_inject();
        logic [FLIT_W-1:0] f;
        f = 144'h0123456789abcdef1857;
        src_valid = 1'b1; src_flit = f; accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            src_flit = rand_flit();
            n_vec++; if (inj !== f)          begin n_err++; $display("FAIL inject_hold_inj cyc%0d got %h exp %h", i, inj, f); end
            n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL inject_hold_ready cyc%0d got %b exp 0", i, src_ready); end
        end
        src_valid = 1'b0; accept = 1'b1;
        tick();
        n_vec++; if (inj !== '0)       begin n_err++; $display("FAIL inject_after_accept_inj got %h exp 0", inj); end
        n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL inject_after_accept_ready got %b exp 1", src_ready); end
        tick();
        accept = 1'b0;
        n_vec++; if (inj !== '0 || src_ready !== 1'b1) begin n_err++; $display("FAIL inject_idle_accept got inj=%h ready=%b exp 0/1", inj, src_ready); end
    endtask

    task automatic test_fill_bfull();
        dst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; eject = rand_flit();
            tick();
            n_vec++; if (bfull !== (i >= 2)) begin n_err++; $display("FAIL fill_bfull push%0d got %b exp %b", i + 1, bfull, i >= 2); end
            n_vec++; if (dst_valid !== 1'b1) begin n_err++; $display("FAIL fill_dst_valid push%0d got %b exp 1", i + 1, dst_valid); end
        end
        push = 1'b0;
        n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL fill_overflow got %b exp 0", overflow); end
        n_vec++; if (dst_flit !== m_q[0]) begin n_err++; $display("FAIL fill_head got %h exp %h", dst_flit, m_q[0]); end
        tick();
        n_vec++; if (dst_flit !== m_q[0]) begin n_err++; $display("FAIL fill_head_stable got %h exp %h", dst_flit, m_q[0]); end
    endtask

    task automatic test_overflow();
        logic [FLIT_W-1:0] x;
        x = rand_flit();
        push = 1'b1; eject = x;
        tick();
        push = 1'b0;
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
        tick();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (dst_valid !== 1'b1 || dst_flit !== m_q[0] || dst_flit === x)
                begin n_err++; $display("FAIL ovf_drain%0d got v=%b %h exp 1 %h", i, dst_valid, dst_flit, m_q[0]); end
            tick();
        end
        dst_ready = 1'b0;
        n_vec++; if (dst_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped got dst_valid=%b exp 0", dst_valid); end
        n_vec++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_sticky_end got %b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        dst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; eject = rand_flit(); tick();
        end
        dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eject = rand_flit();
            n_vec++; if (dst_flit !== m_q[0]) begin n_err++; $display("FAIL wrap_pp_head%0d got %h exp %h", i, dst_flit, m_q[0]); end
            tick();
            n_vec++; if (bfull !== 1'b1 || overflow !== 1'b0 || dst_valid !== 1'b1)
                begin n_err++; $display("FAIL wrap_pp_state%0d got bfull=%b ovf=%b v=%b exp 1/0/1", i, bfull, overflow, dst_valid); end
        end
        push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (dst_valid !== 1'b1 || dst_flit !== m_q[0])
                begin n_err++; $display("FAIL wrap_drain%0d got v=%b %h exp 1 %h", i, dst_valid, dst_flit, m_q[0]); end
            tick();
        end
        dst_ready = 1'b0;
        n_vec++; if (dst_valid !== 1'b0 || bfull !== 1'b0) begin n_err++; $display("FAIL wrap_empty got v=%b bfull=%b exp 0/0", dst_valid, bfull); end
    endtask

    task automatic test_starve();
        src_valid = 1'b1; src_flit = rand_flit(); accept = 1'b0;
        tick();
        src_valid = 1'b0;
        for (int i = 1; i <= LIMIT + 1; i++) begin
            tick();
            if (i == LIMIT - 1 || i >= LIMIT) begin
                n_vec++; if (starve !== (i >= LIMIT)) begin n_err++; $display("FAIL starve_cyc%0d got %b exp %b", i, starve, i >= LIMIT); end
            end
        end
        accept = 1'b1;
        tick();
        accept = 1'b0;
        n_vec++; if (starve !== 1'b0 || src_ready !== 1'b1) begin n_err++; $display("FAIL starve_clear got starve=%b ready=%b exp 0/1", starve, src_ready); end
    endtask

    task automatic test_reset_mid();
        dst_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; eject = rand_flit();
            src_valid = 1'b1; src_flit = rand_flit();
            tick();
        end
        push = 1'b0; src_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (inj !== '0 || dst_valid !== 1'b0 || bfull !== 1'b0 || src_ready !== 1'b1)
            begin n_err++; $display("FAIL reset_mid got inj=%h v=%b bfull=%b ready=%b exp 0/0/0/1", inj, dst_valid, bfull, src_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(299) == 0);
            push      = ($urandom_range(9) < 6);
            eject     = rand_flit();
            dst_ready = ($urandom_range(1) == 1);
            src_valid = ($urandom_range(1) == 1);
            src_flit  = rand_flit();
            accept    = ($urandom_range(99) < ((c % 500) < 150 ? 1 : 30));
            tick();
            n_vec++; if (src_ready !== !m_hold) begin n_err++; $display("FAIL rand_src_ready c%0d got %b exp %b", c, src_ready, !m_hold); end
            n_vec++; if (inj !== m_inj)         begin n_err++; $display("FAIL rand_inj c%0d got %h exp %h", c, inj, m_inj); end
            n_vec++; if (bfull !== m_bfull)     begin n_err++; $display("FAIL rand_bfull c%0d got %b exp %b", c, bfull, m_bfull); end
            n_vec++; if (overflow !== m_overflow) begin n_err++; $display("FAIL rand_overflow c%0d got %b exp %b", c, overflow, m_overflow); end
            n_vec++; if (starve !== (m_hold && m_wait >= LIMIT)) begin n_err++; $display("FAIL rand_starve c%0d got %b exp %b", c, starve, m_hold && m_wait >= LIMIT); end
            n_vec++; if (dst_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rand_dst_valid c%0d got %b exp %b", c, dst_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_vec++; if (dst_flit !== m_q[0]) begin n_err++; $display("FAIL rand_dst_flit c%0d got %h exp %h", c, dst_flit, m_q[0]); end
            end
        end
        rst = 1'b0; push = 1'b0; src_valid = 1'b0; accept = 1'b0; dst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inject();
        test_fill_bfull();
        test_overflow();
        test_full_push_pop_wrap();
        test_starve();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
